// File: rtl/data_memory_responder.sv
// Multi-cycle data memory answering RV32I loads and stores with a BUSYWAIT stall handshake.
// A request is latched in IDLE, held for LATENCY cycles in BUSY, and completes in a one-cycle DONE.
module data_memory_responder #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [2:0]            FUNC3,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITEDATA,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  ERROR
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            func3_q;
    logic [31:0]           wdata_q;
    logic                  is_store_q;
    logic [31:0]           rdata_q;
    logic                  error_q;
    logic [31:0]           mem_q [DEPTH];

    logic [IdxW-1:0] idx;
    logic [1:0]      lane;
    logic [31:0]     word;
    logic            misaligned;
    logic            out_of_range;
    logic            bad_func3;
    logic            fault;
    logic            last_busy;
    logic            commit;
    logic [31:0]     ld_shift;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     load_val;
    logic [31:0]     store_val;
    logic [3:0]      byte_en;

    assign idx       = addr_q[IdxW+1:2];
    assign lane      = addr_q[1:0];
    assign word      = mem_q[idx];
    assign last_busy = (state_q == StBusy) && (cnt_q == '0);
    // Reset on the completing edge must suppress the write.
    assign commit    = RESET && last_busy && is_store_q && !fault;

    // Fault decode works on the latched request, never on the live inputs.
    always_comb begin
        misaligned   = ((func3_q[1:0] == 2'b01) && lane[0]) ||
                       ((func3_q[1:0] == 2'b10) && (lane != 2'b00));
        out_of_range = (addr_q >> 2) >= ADDR_WIDTH'(DEPTH);
        if (is_store_q) begin
            bad_func3 = func3_q[2] || (func3_q[1:0] == 2'b11);
        end else begin
            bad_func3 = (func3_q == 3'b011) || (func3_q[2:1] == 2'b11);
        end
        fault = misaligned || out_of_range || bad_func3;
    end

    always_comb begin
        ld_shift = word >> {lane, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = lane[1] ? word[31:16] : word[15:0];
        load_val = word;
        if (func3_q[1:0] == 2'b00) begin
            load_val = func3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (func3_q[1:0] == 2'b01) begin
            load_val = func3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    // Narrow store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        case (func3_q[1:0])
            2'b00: begin
                store_val = {4{wdata_q[7:0]}};
                byte_en   = 4'b0001 << lane;
            end
            2'b01: begin
                store_val = {2{wdata_q[15:0]}};
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_val = wdata_q;
                byte_en   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            StIdle:  BUSYWAIT = READ ^ WRITE;
            StBusy:  BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (READ && WRITE) begin
                        error_q <= 1'b1;
                    end else if (READ || WRITE) begin
                        addr_q     <= ADDRESS;
                        func3_q    <= FUNC3;
                        wdata_q    <= WRITEDATA;
                        is_store_q <= WRITE;
                        cnt_q      <= CntW'(LATENCY - 1);
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        error_q <= fault;
                        if (!is_store_q) begin
                            rdata_q <= fault ? 32'd0 : load_val;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[idx][8*i +: 8] <= store_val[8*i +: 8];
                end
            end
        end
    end

    assign READDATA = rdata_q;
    assign ERROR    = error_q;

endmodule
